// File: rtl/seq_multiprecision_adder.sv
// Sequential wide adder/subtractor: one CHUNK_WIDTH-bit slice per clock, carry rippled
// through a flop, result assembled in a shift register and published on completion.
module seq_multiprecision_adder #(
  parameter int OPERAND_WIDTH = 64,
  parameter int CHUNK_WIDTH   = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic                     iSub,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iCarry,
  output logic [OPERAND_WIDTH-1:0] oSum,
  output logic                     oCarry,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [1:0]               oState
);

  localparam int NUM_CHUNKS = OPERAND_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  generate
    if ((CHUNK_WIDTH < 1) || (OPERAND_WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_width
      $error("OPERAND_WIDTH must be a positive multiple of CHUNK_WIDTH");
    end
  endgenerate

  // Handshake: iStart is a request sampled only in IDLE; oDone pulses for one cycle
  // when oSum/oCarry update; oBusy marks every cycle a new request would be dropped.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [OPERAND_WIDTH-1:0] r_a;
  logic [OPERAND_WIDTH-1:0] r_b;
  logic [OPERAND_WIDTH-1:0] r_res;
  logic [OPERAND_WIDTH-1:0] r_sum;
  logic                     r_cout;
  logic                     r_carry;
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_last;
  logic [CHUNK_WIDTH:0]     w_slice;
  logic [OPERAND_WIDTH-1:0] w_slice_ext;
  logic [OPERAND_WIDTH-1:0] w_res_next;

  assign w_last      = (r_cnt == CNT_W'(NUM_CHUNKS - 1));
  assign w_slice     = {1'b0, r_a[CHUNK_WIDTH-1:0]} + {1'b0, r_b[CHUNK_WIDTH-1:0]}
                     + {{CHUNK_WIDTH{1'b0}}, r_carry};
  assign w_slice_ext = OPERAND_WIDTH'(w_slice[CHUNK_WIDTH-1:0]);
  // New slice enters at the MSB end so after NUM_CHUNKS shifts slice 0 sits at bit 0.
  assign w_res_next  = (r_res >> CHUNK_WIDTH) | (w_slice_ext << (OPERAND_WIDTH - CHUNK_WIDTH));

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    oBusy        = 1'b1;
    oDone        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        oBusy = 1'b0;
        if (iStart) w_state_next = ST_CALC;
      end
      ST_CALC: if (w_last) w_state_next = ST_DONE;
      ST_DONE: begin
        oDone        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            // Subtract as A + ~B + 1; carry-out then means "no borrow".
            r_a     <= iA;
            r_b     <= iSub ? ~iB : iB;
            r_carry <= iSub ? 1'b1 : iCarry;
            r_cnt   <= '0;
          end
        end
        ST_CALC: begin
          r_a     <= r_a >> CHUNK_WIDTH;
          r_b     <= r_b >> CHUNK_WIDTH;
          r_res   <= w_res_next;
          r_carry <= w_slice[CHUNK_WIDTH];
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_slice[CHUNK_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign oSum   = r_sum;
  assign oCarry = r_cout;
  assign oState = r_state;

endmodule

// File: tb/tb_seq_multiprecision_adder.sv
// Bench for seq_multiprecision_adder: directed vector table, random vectors checked
// against an arithmetic model, busy-start and abort sequences, scoreboard on oDone.
module tb_seq_multiprecision_adder;

  localparam int W  = 64;
  localparam int NC = 4;

  logic         iClk;
  logic         iRst;
  logic         iStart;
  logic         iSub;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iCarry;
  logic [W-1:0] oSum;
  logic         oCarry;
  logic         oBusy;
  logic         oDone;
  logic [1:0]   oState;

  seq_multiprecision_adder #(.OPERAND_WIDTH(W), .CHUNK_WIDTH(16)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iSub(iSub), .iA(iA), .iB(iB),
    .iCarry(iCarry), .oSum(oSum), .oCarry(oCarry), .oBusy(oBusy), .oDone(oDone),
    .oState(oState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int         checks = 0;
  int         errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] held = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_c;
  } vec_t;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic cin);
    logic [W:0] r;
    if (sub) r = {(a >= b), a - b};
    else     r = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
    return r;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Scoreboard: every oDone pulse must match the oldest outstanding expectation.
  always @(negedge iClk) begin
    if (oDone === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {1'b0, oDone}, '0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", {oCarry, oSum}, e);
        held = e;
      end
    end
  end

  // Entered one cycle after the accepting edge; returns on the oDone cycle.
  task automatic wait_done();
    int  lat;
    int  busy;
    bit  seen;
    lat  = 0;
    busy = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (oBusy) busy++;
      if (oDone) begin
        seen = 1;
        break;
      end
      chk("hold_during_calc", {oCarry, oSum}, held);
      @(posedge iClk); #1;
      lat++;
    end
    if (!seen) begin
      chk("done_timeout", {W + 1{1'b0}}, {{W{1'b0}}, 1'b1});
    end else begin
      chk("latency", (W + 1)'(lat), (W + 1)'(NC));
      chk("busy_cycles", (W + 1)'(busy), (W + 1)'(NC + 1));
    end
  endtask

  // Called in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic [W:0] exp);
    iA = a; iB = b; iSub = sub; iCarry = cin; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    exp_q.push_back(exp);
    wait_done();
    @(posedge iClk); #1;
    chk("idle_after_done", {W + 1{1'b0}} | (W + 1)'(oBusy), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic [W-1:0] a, b;
    logic         s, c;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1};
    vecs[1]  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[3]  = '{64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1};
    vecs[4]  = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[5]  = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1};
    vecs[6]  = '{64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[8]  = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[9]  = '{64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0, 1'b1};

    iRst = 1'b1; iStart = 1'b0; iSub = 1'b0; iA = '0; iB = '0; iCarry = 1'b0;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    chk("rst_sum_carry", {oCarry, oSum}, '0);
    chk("rst_busy_done", (W + 1)'({oBusy, oDone}), '0);
    chk("rst_state", (W + 1)'(oState), '0);
    repeat (3) begin
      @(posedge iClk); #1;
      chk("idle_no_done", (W + 1)'(oDone), '0);
    end

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, {vecs[i].exp_c, vecs[i].exp_sum});

    for (int i = 0; i < 500; i++) begin
      a = rand64(); b = rand64();
      if (i % 7 == 0) b = a;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      run_op(a, b, s, c, model(a, b, s, c));
    end

    // Busy start: iStart held high, operands scrambled every cycle.
    a = rand64(); b = rand64(); s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
    iA = a; iB = b; iSub = s; iCarry = c; iStart = 1'b1;
    @(posedge iClk); #1;
    exp_q.push_back(model(a, b, s, c));
    for (int k = 1; k <= NC; k++) begin
      iA = rand64(); iB = rand64(); iSub = ~iSub; iCarry = ~iCarry;
      @(posedge iClk); #1;
      chk("busy_done_pulse", (W + 1)'(oDone), (W + 1)'(k == NC));
    end
    iA = rand64(); iB = rand64();
    @(posedge iClk); #1;
    chk("busy_single_pulse", (W + 1)'({oBusy, oDone}), '0);
    a = rand64(); b = rand64(); s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
    iA = a; iB = b; iSub = s; iCarry = c;
    exp_q.push_back(model(a, b, s, c));
    @(posedge iClk); #1;
    iStart = 1'b0;
    chk("restart_accepted", (W + 1)'(oBusy), (W + 1)'(1));
    wait_done();
    @(posedge iClk); #1;

    // Abort on the second CALC cycle.
    iA = rand64(); iB = rand64(); iSub = 1'b0; iCarry = 1'b1; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    held = '0;
    chk("abort_sum_carry", {oCarry, oSum}, '0);
    chk("abort_busy_done", (W + 1)'({oBusy, oDone}), '0);
    chk("abort_state", (W + 1)'(oState), '0);
    repeat (6) begin
      @(posedge iClk); #1;
      chk("abort_no_done", (W + 1)'(oDone), '0);
    end
    run_op(vecs[1].a, vecs[1].b, vecs[1].sub, vecs[1].cin, {vecs[1].exp_c, vecs[1].exp_sum});

    chk("queue_drained", (W + 1)'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiprecision_adder.md
Name: seq_multiprecision_adder

Overview:
Multi-cycle wide-operand adder/subtractor. It processes OPERAND_WIDTH-bit operands CHUNK_WIDTH bits per clock through one registered CHUNK_WIDTH-bit adder slice, and carries the ripple between slices in a flop. It is the sequential, area-bounded successor to the combinational N-bit ripple adder, used for wide arithmetic (e.g. 256/512-bit) where a full-width carry chain would break timing. It adds a start/done handshake and a subtract mode.

Parameters:
- OPERAND_WIDTH, 64: total operand and result width. Must be an integer multiple of CHUNK_WIDTH. Elaboration fails otherwise.
- CHUNK_WIDTH, 16: bits added per clock. This is the width of the single adder slice.
- NUM_CHUNKS (localparam), OPERAND_WIDTH/CHUNK_WIDTH: number of calculation cycles.

Ports:
- iClk, input, 1: the only clock. All logic updates on its rising edge.
- iRst, input, 1: synchronous, active-high reset.
- iStart, input, 1: start request. Sampled only in IDLE.
- iSub, input, 1: mode select. 0 = add, 1 = subtract. Captured on an accepted start.
- iA, input, OPERAND_WIDTH: operand A. Captured on an accepted start.
- iB, input, OPERAND_WIDTH: operand B. Captured on an accepted start.
- iCarry, input, 1: carry-in for add mode. Captured on an accepted start. Ignored in subtract mode.
- oSum, output, OPERAND_WIDTH: result register.
- oCarry, output, 1: final carry-out. In subtract mode, 1 = no borrow (A >= B).
- oBusy, output, 1: high whenever the state is not IDLE.
- oDone, output, 1: single-cycle pulse when oSum/oCarry become valid.

Behaviour:
- Clock and reset: one clock (iClk); reset iRst is synchronous, active-high.
- Reset values: state = IDLE; oSum = 0; oCarry = 0; oBusy = 0; oDone = 0; internal operand shift registers, carry flop and chunk counter = 0.
- Reset mid-operation: iRst wins over every other condition at that edge. Any calculation in flight is aborted and no oDone is produced.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC: iStart=1 at an edge.
    - rA <= iA.
    - rB <= iB, or ~iB when iSub=1.
    - carry flop <= iCarry (add) or 1 (sub).
    - counter <= 0.
  - CALC: at each edge, slice k = counter is processed.
    - {c, s} = rA[CHUNK_WIDTH-1:0] + rB[CHUNK_WIDTH-1:0] + carry.
    - s is shifted into the MSB end of the result shift register. rA and rB shift right by CHUNK_WIDTH.
    - carry <= c; counter increments.
    - On the edge where counter == NUM_CHUNKS-1: the completed result is written to oSum, oCarry <= c, and the state goes to DONE.
  - DONE: oDone=1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- Latency:
  - Start accepted at edge t; slices are processed at edges t+1 .. t+NUM_CHUNKS.
  - oDone is high during the cycle after edge t+NUM_CHUNKS.
  - Earliest next start is accepted at edge t+NUM_CHUNKS+2 (the first edge in IDLE).
- Handshake:
  - iStart while oBusy=1 (CALC or DONE) is ignored. It is not queued.
  - iA, iB, iSub and iCarry may change freely after the accepting edge.
- Outputs hold:
  - oSum and oCarry keep their last result until the next completion or reset.
  - They do not change during CALC. Partial sums live only in the internal shift register.
- Arithmetic:
  - Add: {oCarry, oSum} = iA + iB + iCarry, exactly, modulo 2^(OPERAND_WIDTH+1).
  - Sub: oSum = (iA - iB) mod 2^OPERAND_WIDTH; oCarry = (iA >= iB), unsigned.
  - Wrap-around is natural modular behaviour. No saturation and no overflow flag.
- Degenerate case: NUM_CHUNKS = 1 is legal and gives 1 CALC cycle.

Test Plan:
Defaults: OPERAND_WIDTH=64, CHUNK_WIDTH=16, NUM_CHUNKS=4.
- Reset: hold iRst for 2 cycles, then release -> oSum=0, oCarry=0, oBusy=0, oDone=0. No oDone appears with iStart=0.
- Full carry ripple across chunks: add A=64'hFFFF_FFFF_FFFF_FFFF, B=0, iCarry=1 -> oDone pulses exactly 4 cycles after the start edge; oSum=0, oCarry=1. oBusy is high for 5 cycles.
- Mixed add: A=64'h0123_4567_89AB_CDEF, B=64'hFEDC_BA98_7654_3210, iCarry=0 -> oSum=64'hFFFF_FFFF_FFFF_FFFF, oCarry=0. Then 500 random add/sub vectors with random iCarry are checked against the golden model, using back-to-back starts issued on the first IDLE cycle.
- Subtract: A=5, B=7, iSub=1 -> oSum=64'hFFFF_FFFF_FFFF_FFFE, oCarry=0. A=7, B=5 -> oSum=2, oCarry=1. iCarry=1 must not change either result.
- Busy start: iStart held high throughout with operands changed each cycle mid-CALC -> the result reflects only the operands captured at the first accepting edge. oDone is a single pulse, followed by a new start accepted one cycle after DONE.
- Abort: assert iRst on the 2nd CALC cycle -> no oDone; outputs are 0 and state is IDLE on the next cycle. A start issued right after reset completes correctly.
